// File: rtl/piezo_tone_player.sv
// rtl/piezo_tone_player.sv - fixed-length square-wave note burst on a judged Perfect hit
module piezo_tone_player #(
   parameter int unsigned DUR_MS    = 100,
   parameter int unsigned MIN_LIMIT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_tick,
   input  logic [1:0]  i_judge,
   input  logic        i_play_en,
   input  logic [31:0] i_cnt_limit,
   output logic        o_piezo,
   output logic        o_busy,
   output logic        o_done
);

   typedef enum logic {IDLE, PLAY} state_t;

   localparam logic [15:0] DUR_INIT  = 16'(DUR_MS);
   localparam logic [31:0] MIN_LIM32 = 32'(MIN_LIMIT);

   state_t      state, state_d;
   logic [1:0]  judge_q;
   logic [31:0] lim_q, lim_d;
   logic [31:0] hp_cnt, hp_d;
   logic [15:0] ms_cnt, ms_d;
   logic        piezo_d, done_d;
   logic        trig;

   // A new Perfect edge with sound enabled and a usable pitch starts (or restarts) a note
   assign trig = (i_judge == 2'b11) && (judge_q != 2'b11) && i_play_en
                 && (i_cnt_limit >= MIN_LIM32);

   // Next-state and next-output decode; retrigger beats abort beats completion
   always_comb begin
      state_d = state;
      lim_d   = lim_q;
      hp_d    = hp_cnt;
      ms_d    = ms_cnt;
      piezo_d = o_piezo;
      done_d  = 1'b0;
      case (state)
         IDLE: begin
            piezo_d = 1'b0;
            if (trig) begin
               state_d = PLAY;
               lim_d   = i_cnt_limit;
               hp_d    = '0;
               ms_d    = DUR_INIT;
            end
         end
         PLAY: begin
            if (trig) begin
               lim_d   = i_cnt_limit;
               hp_d    = '0;
               ms_d    = DUR_INIT;
               piezo_d = 1'b0;
            end else if (!i_play_en) begin
               state_d = IDLE;
               piezo_d = 1'b0;
            end else if (i_tick && (ms_cnt == 16'd1)) begin
               state_d = IDLE;
               piezo_d = 1'b0;
               done_d  = 1'b1;
            end else begin
               if (i_tick) begin
                  ms_d = ms_cnt - 16'd1;
               end
               if (hp_cnt == lim_q - 32'd1) begin
                  hp_d    = '0;
                  piezo_d = ~o_piezo;
               end else begin
                  hp_d = hp_cnt + 32'd1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            piezo_d = 1'b0;
         end
      endcase
   end

   // State and output registers; every output comes straight from a flop
   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= IDLE;
         judge_q <= 2'b00;
         lim_q   <= '0;
         hp_cnt  <= '0;
         ms_cnt  <= '0;
         o_piezo <= 1'b0;
         o_busy  <= 1'b0;
         o_done  <= 1'b0;
      end else begin
         state   <= state_d;
         judge_q <= i_judge;
         lim_q   <= lim_d;
         hp_cnt  <= hp_d;
         ms_cnt  <= ms_d;
         o_piezo <= piezo_d;
         o_busy  <= (state_d == PLAY);
         o_done  <= done_d;
      end
   end

endmodule

// File: tb/tb_piezo_tone_player.sv
// tb/tb_piezo_tone_player.sv - directed self-checking bench for piezo_tone_player
module tb_piezo_tone_player;

   logic        clk;
   logic        rst;
   logic        i_tick;
   logic [1:0]  i_judge;
   logic        i_play_en;
   logic [31:0] i_cnt_limit;
   logic        o_piezo;
   logic        o_busy;
   logic        o_done;

   int n_assert;
   int n_fail;

   piezo_tone_player #(.DUR_MS(3), .MIN_LIMIT(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .i_tick      (i_tick),
      .i_judge     (i_judge),
      .i_play_en   (i_play_en),
      .i_cnt_limit (i_cnt_limit),
      .o_piezo     (o_piezo),
      .o_busy      (o_busy),
      .o_done      (o_done)
   );

   // 100 MHz clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic piezo, input logic busy, input logic done);
      check({tag, "_piezo"}, {31'd0, o_piezo}, {31'd0, piezo});
      check({tag, "_busy"},  {31'd0, o_busy},  {31'd0, busy});
      check({tag, "_done"},  {31'd0, o_done},  {31'd0, done});
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One cycle of judge low, then judge Perfect with the given pitch; returns just after edge N
   task automatic trigger(input logic [31:0] lim, input logic tk);
      i_judge = 2'b00;
      @(negedge clk);
      i_judge     = 2'b11;
      i_cnt_limit = lim;
      i_tick      = tk;
      @(negedge clk);
      i_tick = 1'b0;
   endtask

   task automatic tick();
      i_tick = 1'b1;
      @(negedge clk);
      i_tick = 1'b0;
   endtask

   // Expected waveform k cycles after the trigger edge: low for lim cycles, then high for lim
   task automatic check_wave(input string tag, input int lim, input int cycles);
      for (int k = 0; k < cycles; k++) begin
         check({tag, "_wave"}, {31'd0, o_piezo}, {31'd0, 1'((k / lim) % 2)});
         check({tag, "_busy"}, {31'd0, o_busy}, 32'd1);
         @(negedge clk);
      end
   endtask

   initial begin
      n_assert    = 0;
      n_fail      = 0;
      rst         = 1'b0;
      i_tick      = 1'b0;
      i_judge     = 2'b00;
      i_play_en   = 1'b1;
      i_cnt_limit = 32'd4;

      // Reset held three cycles
      step(3);
      check_out("reset", 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      step(1);
      check_out("post_reset", 1'b0, 1'b0, 1'b0);

      // Basic note, lim 4, three ticks
      trigger(32'd4, 1'b0);
      check_wave("basic", 4, 20);
      tick();
      check_out("basic_t1", o_piezo, 1'b1, 1'b0);
      tick();
      check_out("basic_t2", o_piezo, 1'b1, 1'b0);
      tick();
      check_out("basic_end", 1'b0, 1'b0, 1'b1);
      step(1);
      check_out("basic_done_pulse", 1'b0, 1'b0, 1'b0);

      // Judge still held at Perfect: ticks keep coming, no new note
      for (int i = 0; i < 7; i++) begin
         tick();
         check_out("held", 1'b0, 1'b0, 1'b0);
      end

      // Retrigger with new pitch after two ticks
      trigger(32'd4, 1'b0);
      step(2);
      tick();
      tick();
      check_out("pre_retrig", 1'b1, 1'b1, 1'b0);
      i_cnt_limit = 32'd9;
      trigger(32'd6, 1'b0);
      check_wave("retrig", 6, 14);
      tick();
      check_out("retrig_t1", o_piezo, 1'b1, 1'b0);
      tick();
      check_out("retrig_t2", o_piezo, 1'b1, 1'b0);
      tick();
      check_out("retrig_end", 1'b0, 1'b0, 1'b1);

      // Abort mid-note
      trigger(32'd4, 1'b0);
      step(5);
      check_out("abort_pre", 1'b1, 1'b1, 1'b0);
      i_play_en = 1'b0;
      step(1);
      check_out("abort", 1'b0, 1'b0, 1'b0);
      i_play_en = 1'b1;
      step(2);
      check_out("abort_after", 1'b0, 1'b0, 1'b0);

      // Abort colliding with the final tick
      trigger(32'd4, 1'b0);
      tick();
      tick();
      i_play_en = 1'b0;
      tick();
      check_out("abort_tick", 1'b0, 1'b0, 1'b0);
      i_play_en = 1'b1;

      // Invalid limits ignored, then a valid minimum-limit note
      trigger(32'd1, 1'b0);
      check_out("lim1", 1'b0, 1'b0, 1'b0);
      trigger(32'd0, 1'b0);
      check_out("lim0", 1'b0, 1'b0, 1'b0);
      trigger(32'd2, 1'b0);
      check_wave("lim2", 2, 8);
      tick();
      tick();
      tick();
      check_out("lim2_end", 1'b0, 1'b0, 1'b1);

      // Tick in the trigger cycle is not counted
      trigger(32'd4, 1'b1);
      check_out("coll", 1'b0, 1'b1, 1'b0);
      tick();
      check_out("coll_t1", o_piezo, 1'b1, 1'b0);
      tick();
      check_out("coll_t2", o_piezo, 1'b1, 1'b0);
      tick();
      check_out("coll_end", 1'b0, 1'b0, 1'b1);

      // Reset mid-note
      trigger(32'd2, 1'b0);
      step(3);
      check_out("rst_pre", 1'b1, 1'b1, 1'b0);
      rst     = 1'b0;
      i_judge = 2'b00;
      step(1);
      check_out("rst_mid", 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      step(2);
      check_out("rst_after", 1'b0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
